// File: rtl/lcd_prefetch_pkg.sv
// Shared definitions for the LCD frame prefetch stage: FSM encoding,
// default panel geometry and RGB565 field positions.
package lcd_prefetch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        DATA  = 3'd2,
        DRAIN = 3'd3,
        FLUSH = 3'd4
    } state_t;

    // Source of the pixel presented to the driver one cycle after a request
    typedef enum logic [1:0] {
        PIX_BLANK    = 2'd0,
        PIX_UNDERRUN = 2'd1,
        PIX_FIFO     = 2'd2
    } pix_sel_t;

    localparam int H_ACTIVE        = 640;
    localparam int V_ACTIVE        = 480;
    localparam int FRAME_WORDS_DEF = H_ACTIVE * V_ACTIVE;

    localparam int FETCH_W = 20;
    localparam int LEN_W   = 9;

    localparam int RGB_R_MSB = 15;
    localparam int RGB_R_LSB = 11;
    localparam int RGB_G_MSB = 10;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_B_MSB = 4;
    localparam int RGB_B_LSB = 0;

endpackage

// File: rtl/lcd_prefetch_fifo.sv
// Single-clock pixel FIFO with synchronous clear and registered read data
// (pop_data updates on the edge that performs the pop).
module lcd_prefetch_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && (count != FULL_CNT) && !clear;
    assign do_pop  = pop && (count != '0) && !clear;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
        if (do_pop)  pop_data    <= mem[rd_ptr];
    end

endmodule

// File: rtl/lcd_frame_prefetch.sv
// Prefetches one frame of pixels from SDRAM in bursts into a FIFO and serves
// the LCD driver's one-cycle-ahead pixel requests; restarts on each vsync.
module lcd_frame_prefetch
    import lcd_prefetch_pkg::*;
#(
    parameter int                 DATA_W         = 16,
    parameter int                 DEPTH          = 512,
    parameter int                 ADDR_W         = 22,
    parameter int                 BURST_LEN      = 256,
    parameter int                 FRAME_WORDS    = FRAME_WORDS_DEF,
    parameter logic [ADDR_W-1:0]  FRAME_BASE     = '0,
    parameter logic [DATA_W-1:0]  UNDERRUN_PIXEL = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lcd_request,
    input  logic                   lcd_framesync,
    output logic [DATA_W-1:0]      lcd_data,
    output logic                   rd_req,
    output logic [ADDR_W-1:0]      rd_addr,
    output logic [LEN_W-1:0]       rd_len,
    input  logic                   rd_ack,
    input  logic                   rd_valid,
    input  logic [DATA_W-1:0]      rd_data,
    output logic                   underflow,
    output logic [$clog2(DEPTH):0] fill_level
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [FETCH_W-1:0] FRAME_CNT = FETCH_W'(FRAME_WORDS);
    localparam logic [FETCH_W-1:0] BURST_CNT = FETCH_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]   DEPTH_LVL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]   BURST_LVL = CNT_W'(BURST_LEN);

    state_t              state;
    state_t              state_nxt;
    logic                fs_d;
    logic                frame_start;
    logic [FETCH_W-1:0]  fetched;
    logic [FETCH_W-1:0]  remaining;
    logic [LEN_W-1:0]    burst_len;
    logic [LEN_W-1:0]    beats_left;
    logic                space_ok;
    logic                more_to_fetch;
    logic                push;
    logic                pop;
    logic                fifo_clear;
    logic [DATA_W-1:0]   fifo_q;
    pix_sel_t            pix_sel_p1;

    function automatic logic [FETCH_W-1:0] sat_inc(input logic [FETCH_W-1:0] v);
        return (v < FRAME_CNT) ? v + 1'b1 : v;
    endfunction

    assign frame_start   = fs_d & ~lcd_framesync;
    assign remaining     = FRAME_CNT - fetched;
    assign burst_len     = (remaining < BURST_CNT) ? remaining[LEN_W-1:0] : BURST_CNT[LEN_W-1:0];
    // Only one burst is ever in flight, so free space alone gates the next one
    assign space_ok      = (DEPTH_LVL - fill_level) >= BURST_LVL;
    assign more_to_fetch = fetched < FRAME_CNT;
    assign rd_addr       = FRAME_BASE + ADDR_W'(fetched);
    assign pop           = lcd_request && (fill_level != '0) && (state != FLUSH);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (frame_start)                  state_nxt = FLUSH;
                else if (more_to_fetch && space_ok) state_nxt = REQ;
            end
            REQ: begin
                if (rd_ack)           state_nxt = frame_start ? DRAIN : DATA;
                else if (frame_start) state_nxt = FLUSH;
            end
            DATA: begin
                if (frame_start)                                state_nxt = DRAIN;
                else if (rd_valid && beats_left == LEN_W'(1))   state_nxt = IDLE;
            end
            DRAIN: begin
                if (beats_left == '0 || (rd_valid && beats_left == LEN_W'(1)))
                    state_nxt = FLUSH;
            end
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_req     = 1'b0;
        rd_len     = '0;
        push       = 1'b0;
        fifo_clear = 1'b0;
        case (state)
            REQ: begin
                rd_req = 1'b1;
                rd_len = burst_len;
            end
            DATA:    push       = rd_valid;
            FLUSH:   fifo_clear = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fs_d       <= 1'b1;
            fetched    <= '0;
            beats_left <= '0;
            underflow  <= 1'b0;
            pix_sel_p1 <= PIX_BLANK;
        end else begin
            fs_d <= lcd_framesync;

            case (state)
                REQ:         if (rd_ack) beats_left <= burst_len;
                DATA, DRAIN: if (rd_valid && beats_left != '0) beats_left <= beats_left - 1'b1;
                default: ;
            endcase

            if (state == FLUSH) fetched <= '0;
            else if (push)      fetched <= sat_inc(fetched);

            if (state == FLUSH)             underflow <= 1'b0;
            else if (lcd_request && !pop)   underflow <= 1'b1;

            // Stage p1: which source drives lcd_data on the following cycle
            if (!lcd_request) pix_sel_p1 <= PIX_BLANK;
            else if (pop)     pix_sel_p1 <= PIX_FIFO;
            else              pix_sel_p1 <= PIX_UNDERRUN;
        end
    end

    always_comb begin
        case (pix_sel_p1)
            PIX_FIFO:     lcd_data = fifo_q;
            PIX_UNDERRUN: lcd_data = UNDERRUN_PIXEL;
            default:      lcd_data = '0;
        endcase
    end

    lcd_prefetch_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (fifo_clear),
        .push      (push),
        .push_data (rd_data),
        .pop       (pop),
        .pop_data  (fifo_q),
        .count     (fill_level)
    );

endmodule

// File: tb/tb_lcd_frame_prefetch.sv
// Bench for lcd_frame_prefetch: SDRAM responder plus a queue-based model of the
// prefetched pixel stream, driven with randomized request/ack/beat timing.
module tb_lcd_frame_prefetch;

    localparam int DATA_W      = 16;
    localparam int DEPTH       = 512;
    localparam int ADDR_W      = 22;
    localparam int BURST_LEN   = 256;
    localparam int FRAME_WORDS = 600;
    localparam logic [15:0] UNDER = 16'h0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              lcd_request;
    logic              lcd_framesync;
    logic [15:0]       lcd_data;
    logic              rd_req;
    logic [21:0]       rd_addr;
    logic [8:0]        rd_len;
    logic              rd_ack;
    logic              rd_valid;
    logic [15:0]       rd_data;
    logic              underflow;
    logic [9:0]        fill_level;

    always #5 clk = ~clk;

    lcd_frame_prefetch #(
        .DATA_W         (DATA_W),
        .DEPTH          (DEPTH),
        .ADDR_W         (ADDR_W),
        .BURST_LEN      (BURST_LEN),
        .FRAME_WORDS    (FRAME_WORDS),
        .FRAME_BASE     (22'd0),
        .UNDERRUN_PIXEL (UNDER)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .lcd_request   (lcd_request),
        .lcd_framesync (lcd_framesync),
        .lcd_data      (lcd_data),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_len        (rd_len),
        .rd_ack        (rd_ack),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .underflow     (underflow),
        .fill_level    (fill_level)
    );

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [15:0] model_q[$];
    int          model_fetched;
    bit          model_uf;
    bit          in_burst;
    int          beats_rem;
    bit          req_seen;
    bit          chk_pending;
    logic [15:0] chk_exp;
    int          bursts_issued;

    function automatic int exp_len(input int f);
        return (FRAME_WORDS - f < BURST_LEN) ? FRAME_WORDS - f : BURST_LEN;
    endfunction

    task automatic model_reset();
        model_q.delete();
        model_fetched = 0;
        model_uf      = 1'b0;
        in_burst      = 1'b0;
        beats_rem     = 0;
        req_seen      = 1'b0;
        chk_pending   = 1'b0;
        bursts_issued = 0;
    endtask

    // One clock of activity, called at a negedge: check, then drive the next edge.
    task automatic step(input bit want_req, input int ack_pct, input int beat_pct);
        total_cnt++;
        if (fill_level !== 10'(model_q.size())) $display("FAIL fill_level: got %0d expected %0d", fill_level, model_q.size());
        else pass_cnt++;
        total_cnt++;
        if (underflow !== model_uf) $display("FAIL underflow: got %0b expected %0b", underflow, model_uf);
        else pass_cnt++;
        if (chk_pending) begin
            total_cnt++;
            if (lcd_data !== chk_exp) $display("FAIL lcd_data: got %04h expected %04h", lcd_data, chk_exp);
            else pass_cnt++;
        end
        if (rd_req && !req_seen) begin
            req_seen = 1'b1;
            bursts_issued++;
            total_cnt++;
            if (model_fetched >= FRAME_WORDS || rd_addr !== 22'(model_fetched) || rd_len !== 9'(exp_len(model_fetched)))
                $display("FAIL burst_req: got addr %0d len %0d expected addr %0d len %0d", rd_addr, rd_len, model_fetched, exp_len(model_fetched));
            else pass_cnt++;
        end
        rd_ack   = 1'b0;
        rd_valid = 1'b0;
        lcd_request = want_req;
        if (want_req) begin
            if (model_q.size() > 0) chk_exp = model_q.pop_front();
            else begin
                chk_exp  = UNDER;
                model_uf = 1'b1;
            end
        end else chk_exp = '0;
        chk_pending = 1'b1;
        if (in_burst) begin
            if ($urandom_range(1, 100) <= beat_pct) begin
                total_cnt++;
                if (fill_level == 10'(DEPTH)) $display("FAIL push_when_full: fill_level %0d expected below %0d", fill_level, DEPTH);
                else pass_cnt++;
                rd_valid = 1'b1;
                rd_data  = 16'(model_fetched + 1);
                model_q.push_back(rd_data);
                model_fetched++;
                beats_rem--;
                if (beats_rem == 0) in_burst = 1'b0;
            end
        end else if (rd_req && ack_pct > 0 && $urandom_range(1, 100) <= ack_pct) begin
            rd_ack    = 1'b1;
            in_burst  = 1'b1;
            beats_rem = exp_len(model_fetched);
            req_seen  = 1'b0;
        end
        @(negedge clk);
    endtask

    // Falling vsync; any outstanding beats are delivered and must be discarded.
    task automatic frame_restart();
        lcd_request   = 1'b0;
        rd_ack        = 1'b0;
        rd_valid      = 1'b0;
        chk_pending   = 1'b0;
        lcd_framesync = 1'b0;
        @(negedge clk);
        lcd_framesync = 1'b1;
        while (in_burst) begin
            rd_valid = 1'b1;
            rd_data  = 16'hBAD0;
            beats_rem--;
            if (beats_rem == 0) in_burst = 1'b0;
            @(negedge clk);
        end
        rd_valid = 1'b0;
        repeat (2) @(negedge clk);
        model_q.delete();
        model_fetched = 0;
        model_uf      = 1'b0;
        req_seen      = 1'b0;
        total_cnt++;
        if (fill_level !== 10'd0) $display("FAIL restart_fill: got %0d expected 0", fill_level);
        else pass_cnt++;
        total_cnt++;
        if (underflow !== 1'b0) $display("FAIL restart_underflow: got %0b expected 0", underflow);
        else pass_cnt++;
    endtask

    task automatic check_reset_values(input string tag);
        total_cnt++;
        if (lcd_data !== 16'h0) $display("FAIL %s_lcd_data: got %04h expected 0000", tag, lcd_data); else pass_cnt++;
        total_cnt++;
        if (rd_req !== 1'b0) $display("FAIL %s_rd_req: got %0b expected 0", tag, rd_req); else pass_cnt++;
        total_cnt++;
        if (rd_addr !== 22'd0) $display("FAIL %s_rd_addr: got %0d expected 0", tag, rd_addr); else pass_cnt++;
        total_cnt++;
        if (rd_len !== 9'd0) $display("FAIL %s_rd_len: got %0d expected 0", tag, rd_len); else pass_cnt++;
        total_cnt++;
        if (underflow !== 1'b0) $display("FAIL %s_underflow: got %0b expected 0", tag, underflow); else pass_cnt++;
        total_cnt++;
        if (fill_level !== 10'd0) $display("FAIL %s_fill_level: got %0d expected 0", tag, fill_level); else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; lcd_request = 1'b0; lcd_framesync = 1'b1;
        rd_ack = 1'b0; rd_valid = 1'b0; rd_data = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_fill();
        int extra = 0;
        for (int n = 0; n < 3000 && !(model_fetched == 512 && !in_burst); n++) step(1'b0, 100, 100);
        total_cnt++;
        if (!(model_fetched == 512 && !in_burst)) $display("FAIL fill_timeout: fetched %0d expected 512", model_fetched);
        else pass_cnt++;
        total_cnt++;
        if (fill_level !== 10'd512) $display("FAIL fill_full: got %0d expected 512", fill_level); else pass_cnt++;
        total_cnt++;
        if (bursts_issued != 2) $display("FAIL fill_bursts: got %0d expected 2", bursts_issued); else pass_cnt++;
        for (int n = 0; n < 40; n++) begin
            if (rd_req) extra++;
            step(1'b0, 100, 100);
        end
        total_cnt++;
        if (extra != 0) $display("FAIL no_third_burst: rd_req cycles %0d expected 0", extra); else pass_cnt++;
    endtask

    task automatic test_stream();
        for (int n = 0; n < 300; n++) step(1'b1, 100, 100);
    endtask

    task automatic test_frame_end();
        int late = 0;
        for (int n = 0; n < 5000 && !(model_fetched == FRAME_WORDS && !in_burst && model_q.size() == 0); n++)
            step(1'($urandom_range(0, 1)), 60, 70);
        total_cnt++;
        if (model_fetched != FRAME_WORDS || model_q.size() != 0)
            $display("FAIL frame_end_timeout: fetched %0d expected %0d", model_fetched, FRAME_WORDS);
        else pass_cnt++;
        total_cnt++;
        if (bursts_issued != 3) $display("FAIL frame_bursts: got %0d expected 3", bursts_issued); else pass_cnt++;
        for (int n = 0; n < 30; n++) begin
            if (rd_req) late++;
            step(1'(n < 5), 100, 100);
        end
        total_cnt++;
        if (late != 0) $display("FAIL rd_req_after_frame: got %0d cycles expected 0", late); else pass_cnt++;
    endtask

    task automatic test_stall_underrun();
        frame_restart();
        bursts_issued = 0;
        for (int n = 0; n < 12; n++) step(1'b1, 0, 0);
        total_cnt++;
        if (rd_req !== 1'b1) $display("FAIL stall_rd_req: got %0b expected 1", rd_req); else pass_cnt++;
        total_cnt++;
        if (underflow !== 1'b1) $display("FAIL stall_underflow: got %0b expected 1", underflow); else pass_cnt++;
        frame_restart();
    endtask

    task automatic test_vsync_mid_burst();
        bit seen = 1'b0;
        for (int n = 0; n < 500 && model_fetched < 100; n++) step(1'b0, 100, 100);
        total_cnt++;
        if (model_fetched != 100 || beats_rem != 156) $display("FAIL mid_burst_setup: fetched %0d expected 100", model_fetched);
        else pass_cnt++;
        frame_restart();
        for (int n = 0; n < 20 && !seen; n++) begin
            if (rd_req) seen = 1'b1;
            else step(1'b0, 0, 0);
        end
        total_cnt++;
        if (!seen || rd_addr !== 22'd0 || rd_len !== 9'd256)
            $display("FAIL restart_burst: got req %0b addr %0d len %0d expected 1 0 256", seen, rd_addr, rd_len);
        else pass_cnt++;
        for (int n = 0; n < 150; n++) step(1'($urandom_range(0, 3) == 0), 100, 90);
    endtask

    task automatic test_reset_mid_burst();
        frame_restart();
        for (int n = 0; n < 500 && model_fetched < 40; n++) step(1'b0, 100, 100);
        rst = 1'b1; rd_valid = 1'b1; rd_data = 16'h5555; rd_ack = 1'b0; lcd_request = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("mid_reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rd_valid = 1'b0;
        total_cnt++;
        if (fill_level !== 10'd0) $display("FAIL stray_beats_fill: got %0d expected 0", fill_level); else pass_cnt++;
        model_reset();
        for (int n = 0; n < 1000 && !(model_fetched >= 256 && !in_burst); n++) step(1'($urandom_range(0, 4) == 0), 100, 80);
        total_cnt++;
        if (model_fetched < 256) $display("FAIL refetch_timeout: fetched %0d expected 256", model_fetched); else pass_cnt++;
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            frame_restart();
            for (int n = 0; n < $urandom_range(100, 700); n++)
                step(1'($urandom_range(0, 2) != 0), 50, 75);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_frame_end();
        test_stall_underrun();
        test_vsync_mid_burst();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/lcd_frame_prefetch.md
Name: lcd_frame_prefetch

Overview:
- Pixel-side prefetch stage that sits directly upstream of the LCD/VGA timing driver.
- Issues burst read requests to the SDRAM read port and buffers the returned pixels in an on-chip FIFO.
- Answers the driver's one-cycle-ahead pixel request with registered data.
- Restarts at the frame base address on every vertical sync.

Parameters:
- DATA_W, 16, pixel width (RGB565)
- DEPTH, 512, FIFO depth in pixels (power of two)
- ADDR_W, 22, SDRAM word address width
- BURST_LEN, 256, maximum pixels per read burst; must be <= DEPTH/2
- FRAME_WORDS, 307200, pixels per frame (640x480)
- FRAME_BASE, 0, SDRAM word address of pixel (0,0)
- UNDERRUN_PIXEL, 16'h0000, value driven when the FIFO is empty on a request

Ports:
- clk, in, 1, pixel clock; the only clock
- rst, in, 1, synchronous active-high reset
- lcd_request, in, 1, driver pixel request, one cycle ahead of display enable
- lcd_framesync, in, 1, driver vsync (active low)
- lcd_data, out, DATA_W, pixel to driver, valid the cycle after lcd_request
- rd_req, out, 1, burst request to SDRAM read port
- rd_addr, out, ADDR_W, burst start address
- rd_len, out, 9, burst length in words (1..BURST_LEN)
- rd_ack, in, 1, SDRAM accepted the burst
- rd_valid, in, 1, read beat valid
- rd_data, in, DATA_W, read beat data
- underflow, out, 1, sticky: a request found the FIFO empty this frame
- fill_level, out, log2(DEPTH)+1, current FIFO occupancy

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: lcd_data=0, rd_req=0, rd_addr=FRAME_BASE, rd_len=0, underflow=0, fill_level=0, FIFO empty, state=IDLE, fetched=0.
- Frame start event: fs_d<=lcd_framesync every cycle; frame_start = fs_d & ~lcd_framesync (falling edge of vsync).
- FSM states:
  - IDLE
    - frame_start -> FLUSH.
    - fetched<FRAME_WORDS and (DEPTH-fill_level)>=BURST_LEN -> REQ.
    - otherwise stay.
  - REQ
    - rd_req=1; rd_addr=FRAME_BASE+fetched; rd_len=min(BURST_LEN, FRAME_WORDS-fetched). All held stable until rd_ack.
    - rd_ack -> DATA, beats_left<=rd_len, rd_req<=0.
    - frame_start while rd_req=1 and no rd_ack: drop the request -> FLUSH.
    - rd_ack and frame_start in the same cycle: go to DRAIN.
  - DATA
    - Each rd_valid pushes rd_data, decrements beats_left, increments fetched.
    - Last beat -> IDLE.
    - frame_start -> DRAIN (remaining beats must still be consumed).
  - DRAIN
    - rd_valid beats are counted and discarded, not pushed.
    - When beats_left reaches 0 -> FLUSH.
  - FLUSH
    - One cycle: FIFO cleared, fetched<=0, underflow<=0 -> IDLE.
- Only one burst is ever outstanding, so the space check needs no credit for in-flight data.
- rd_valid outside DATA/DRAIN is ignored.
- Pixel read path, latency 1:
  - Cycle with lcd_request=1 and FIFO non-empty: pop; lcd_data<=head next edge.
  - lcd_request=1 and FIFO empty: lcd_data<=UNDERRUN_PIXEL, underflow<=1, no pop.
  - lcd_request=0: lcd_data<=0.
- Simultaneous push and pop: both happen; fill_level unchanged.
- Push when full cannot occur by construction; the assertion in the bench must hold.
- Requests during FLUSH behave as empty (underrun).
- Arithmetic:
  - fetched is 20 bits, saturates at FRAME_WORDS.
  - rd_addr sum is truncated to ADDR_W.
  - rd_len derivation uses unsigned 20-bit compare.
- Reset mid-burst: all state returns to reset values. Late rd_valid beats after reset are ignored because the state is IDLE.

Decomposition:
- Shared package (lcd_prefetch_pkg):
  - State encoding constants IDLE/REQ/DATA/DRAIN/FLUSH.
  - Default frame geometry constants (640, 480, FRAME_WORDS).
  - RGB565 field positions.
- One sub-module: lcd_prefetch_fifo.
  - Single-clock, DEPTH x DATA_W.
  - push/pop/clear inputs; count output; registered read data, latency 1.
  - The top keeps the FSM, address counters and the frame-start detector.

Test Plan:
- Reset then idle (lcd_framesync=1) -> first rd_req with rd_addr=0, rd_len=256; after rd_ack plus 256 beats fill_level=256; a second burst at rd_addr=256 is issued; no third burst while fill_level>256.
- Request stream on a full FIFO holding 0x0001,0x0002,... -> lcd_data shows 0x0001 exactly one cycle after the first lcd_request; each popped word appears in order with no gaps.
- FRAME_WORDS=600, BURST_LEN=256 -> bursts of rd_len 256, 256, 88 at addresses 0, 256, 512; no further rd_req until vsync.
- Requests with the SDRAM stalled (never acks) -> lcd_data=0x0000 (UNDERRUN_PIXEL) and underflow=1 from the first empty request; underflow clears on the next falling edge of lcd_framesync.
- Falling edge of lcd_framesync after 100 of 256 beats -> the remaining 156 beats are discarded; FIFO is cleared; the next rd_req has rd_addr=FRAME_BASE, rd_len=256.
- rst=1 asserted during DATA, then released -> all outputs return to reset values; stray rd_valid beats leave fill_level=0; normal fetch restarts at address 0.
